// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Shared types and geometry constants for the 2-way data cache.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Default geometry
    localparam int          CACHE_SETS        = 64;
    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;

    // Block of two 32-bit words
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 2 * WORD_W;

    // The offset (addr - ADDR_BASE) is decoded up to this bit; everything
    // above it is ignored by the cache.
    localparam int OFF_MSB = 18;

    localparam int IDX_W = $clog2(CACHE_SETS);
    localparam int TAG_W = OFF_MSB - 2 - IDX_W;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL0 = 3'd1,
        ST_FILL1 = 3'd2,
        ST_DONE  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    // Tag width for an arbitrary power-of-two set count
    function automatic int tag_width(input int sets);
        return OFF_MSB - 2 - $clog2(sets);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_2way.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_2way
//  Purpose  : Valid/tag/data/LRU storage of the 2-way cache. Lookup is
//             combinational; all updates happen on the rising clock edge.
//             The LRU bit of a set names the way to evict next.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_mem_2way
    import cache_pkg::*;
#(
    parameter int SETS   = CACHE_SETS,
    parameter int IDX_W_P = $clog2(SETS),
    parameter int TAG_W_P = tag_width(SETS)
) (
    input  logic               clk,
    input  logic               rst,
    // lookup
    input  logic [IDX_W_P-1:0] idx_i,
    input  logic [TAG_W_P-1:0] tag_i,
    input  logic               wsel_i,
    output logic               hit_o,
    output logic               hit_way_o,
    output logic [WORD_W-1:0]  hit_word_o,
    output logic               victim_way_o,
    // block fill
    input  logic               fill_en_i,
    input  logic               fill_way_i,
    input  logic [BLOCK_W-1:0] fill_data_i,
    // single-word update on write hit
    input  logic               word_wr_en_i,
    input  logic               word_way_i,
    input  logic [WORD_W-1:0]  word_data_i,
    // LRU update
    input  logic               lru_wr_en_i,
    input  logic               lru_val_i
);

    logic [SETS-1:0]    valid0_q, valid1_q, lru_q;
    logic [TAG_W_P-1:0] tag0_q  [SETS];
    logic [TAG_W_P-1:0] tag1_q  [SETS];
    logic [BLOCK_W-1:0] data0_q [SETS];
    logic [BLOCK_W-1:0] data1_q [SETS];

    logic               w_hit0, w_hit1;
    logic [BLOCK_W-1:0] w_blk;

    // Combinational tag compare, word select and victim choice
    always_comb begin
        w_hit0       = valid0_q[idx_i] && (tag0_q[idx_i] == tag_i);
        w_hit1       = valid1_q[idx_i] && (tag1_q[idx_i] == tag_i);
        hit_o        = w_hit0 || w_hit1;
        hit_way_o    = w_hit1 && !w_hit0;
        w_blk        = hit_way_o ? data1_q[idx_i] : data0_q[idx_i];
        hit_word_o   = wsel_i ? w_blk[BLOCK_W-1:WORD_W] : w_blk[WORD_W-1:0];
        if (!valid0_q[idx_i]) begin
            victim_way_o = 1'b0;
        end else if (!valid1_q[idx_i]) begin
            victim_way_o = 1'b1;
        end else begin
            victim_way_o = lru_q[idx_i];
        end
    end

    // Valid and LRU bits: cleared by reset, set by fills / accesses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            if (fill_en_i) begin
                if (fill_way_i) begin
                    valid1_q[idx_i] <= 1'b1;
                end else begin
                    valid0_q[idx_i] <= 1'b1;
                end
            end
            if (lru_wr_en_i) begin
                lru_q[idx_i] <= lru_val_i;
            end
        end
    end

    // Tag and data arrays; contents are meaningless until valid is set
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            if (fill_way_i) begin
                tag1_q[idx_i]  <= tag_i;
                data1_q[idx_i] <= fill_data_i;
            end else begin
                tag0_q[idx_i]  <= tag_i;
                data0_q[idx_i] <= fill_data_i;
            end
        end else if (word_wr_en_i) begin
            if (word_way_i) begin
                if (wsel_i) data1_q[idx_i][BLOCK_W-1:WORD_W] <= word_data_i;
                else        data1_q[idx_i][WORD_W-1:0]       <= word_data_i;
            end else begin
                if (wsel_i) data0_q[idx_i][BLOCK_W-1:WORD_W] <= word_data_i;
                else        data0_q[idx_i][WORD_W-1:0]       <= word_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cache_controller
//  Purpose  : 2-way set-associative, write-through / no-write-allocate data
//             cache between the MEM stage and the SramController. Read hits
//             complete combinationally; misses fill a 2-word block.
//             Optional feature macro: CACHE_STATS_EN (hit/miss counters).
//  Revision : 1.0 - initial release
// ============================================================================
module cache_controller
    import cache_pkg::*;
#(
    parameter int          SETS      = CACHE_SETS,
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        sram_rd_en_o,
    output logic        sram_wr_en_o,
    output logic [31:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i,
    input  logic        sram_ready_i,
    output logic [15:0] hit_cnt_o,
    output logic [15:0] miss_cnt_o
);

    localparam int IW = $clog2(SETS);
    localparam int TW = tag_width(SETS);

    state_t      state_q, state_d;
    logic        first_q, first_d;       // first cycle of a wait state
    logic        was_fill_q, was_fill_d; // DONE follows a block fill
    logic [31:0] word0_q, word0_d;
    logic [31:0] word1_q, word1_d;

    logic [31:0] w_offset;
    logic        w_wsel;
    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic        w_unused_off;

    logic        w_hit, w_hit_way, w_victim;
    logic [31:0] w_hit_word;
    logic        w_fill_en, w_word_wr_en, w_lru_wr_en, w_lru_val;
    logic        w_inc_hit, w_inc_miss;
    logic        w_sram_done;

    assign w_offset     = addr_i - ADDR_BASE;
    assign w_wsel       = w_offset[2];
    assign w_idx        = w_offset[IW+2:3];
    assign w_tag        = w_offset[OFF_MSB:IW+3];
    assign w_unused_off = ^{w_offset[31:OFF_MSB+1], w_offset[1:0]};

    // SRAM completion is only honoured once the request has been visible
    // for a full cycle; a ready left over from idle must not be taken.
    assign w_sram_done  = sram_ready_i && !first_q;

    cache_mem_2way #(
        .SETS    (SETS),
        .IDX_W_P (IW),
        .TAG_W_P (TW)
    ) u_mem (
        .clk          (clk),
        .rst          (rst),
        .idx_i        (w_idx),
        .tag_i        (w_tag),
        .wsel_i       (w_wsel),
        .hit_o        (w_hit),
        .hit_way_o    (w_hit_way),
        .hit_word_o   (w_hit_word),
        .victim_way_o (w_victim),
        .fill_en_i    (w_fill_en),
        .fill_way_i   (w_victim),
        .fill_data_i  ({sram_rdata_i, word0_q}),
        .word_wr_en_i (w_word_wr_en),
        .word_way_i   (w_hit_way),
        .word_data_i  (wdata_i),
        .lru_wr_en_i  (w_lru_wr_en),
        .lru_val_i    (w_lru_val)
    );

    // State and fill-buffer registers; reset aborts any transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b0;
            was_fill_q <= 1'b0;
            word0_q    <= '0;
            word1_q    <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            was_fill_q <= was_fill_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
        end
    end

    // Next-state, handshake outputs and array update strobes
    always_comb begin
        state_d      = state_q;
        first_d      = 1'b0;
        was_fill_d   = was_fill_q;
        word0_d      = word0_q;
        word1_d      = word1_q;
        ready_o      = 1'b0;
        rdata_o      = w_wsel ? word1_q : word0_q;
        sram_rd_en_o = 1'b0;
        sram_wr_en_o = 1'b0;
        sram_addr_o  = addr_i;
        sram_wdata_o = wdata_i;
        w_fill_en    = 1'b0;
        w_word_wr_en = 1'b0;
        w_lru_wr_en  = 1'b0;
        w_lru_val    = 1'b0;
        w_inc_hit    = 1'b0;
        w_inc_miss   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_en_i) begin
                    state_d = ST_WRITE;
                    first_d = 1'b1;
                end else if (rd_en_i) begin
                    if (w_hit) begin
                        ready_o     = 1'b1;
                        rdata_o     = w_hit_word;
                        w_lru_wr_en = 1'b1;
                        w_lru_val   = ~w_hit_way;
                        w_inc_hit   = 1'b1;
                    end else begin
                        state_d = ST_FILL0;
                        first_d = 1'b1;
                    end
                end else begin
                    ready_o = 1'b1;
                end
            end
            ST_FILL0: begin
                sram_rd_en_o = 1'b1;
                sram_addr_o  = {addr_i[31:3], 3'b000};
                if (w_sram_done) begin
                    word0_d = sram_rdata_i;
                    state_d = ST_FILL1;
                    first_d = 1'b1;
                end
            end
            ST_FILL1: begin
                sram_rd_en_o = 1'b1;
                sram_addr_o  = {addr_i[31:3], 3'b100};
                if (w_sram_done) begin
                    word1_d     = sram_rdata_i;
                    w_fill_en   = 1'b1;
                    w_lru_wr_en = 1'b1;
                    w_lru_val   = ~w_victim;
                    was_fill_d  = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_o    = 1'b1;
                w_inc_miss = was_fill_q;
                was_fill_d = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_WRITE: begin
                sram_wr_en_o = 1'b1;
                if (w_sram_done) begin
                    w_word_wr_en = w_hit;
                    was_fill_d   = 1'b0;
                    state_d      = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (w_inc_hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (w_inc_miss && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic w_unused_stats;

    assign hit_cnt_o      = '0;
    assign miss_cnt_o     = '0;
    assign w_unused_stats = w_inc_hit ^ w_inc_miss;
`endif

endmodule
`default_nettype wire

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SETS, 64, number of sets; power of two; index width is log2(SETS).
REQ-002 ADDR_BASE, 1024, data-memory base subtracted from the byte address before index/tag extraction.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rd_en  input  1  MEM-stage read request; held with addr until ready=1.
REQ-006 wr_en  input  1  MEM-stage write request; held with addr/wdata until ready=1.
REQ-007 addr  input  32  byte address (word-aligned).
REQ-008 wdata  input  32  store data.
REQ-009 rdata  output  32  load data; valid while ready=1 and a read is being completed.
REQ-010 ready  output  1  0 freezes the pipeline; 1 completes the request.
REQ-011 sram_rd_en, sram_wr_en  output  1 each  requests to SramController.
REQ-012 sram_addr  output  32  full byte address to SramController (ADDR_BASE not removed).
REQ-013 sram_wdata  output  32  store data to SramController.
REQ-014 sram_rdata  input  32  SramController read data.
REQ-015 sram_ready  input  1  SramController ready (combinational; 0 while busy).
REQ-016 hit_cnt, miss_cnt  output  16 each  statistics (see Configuration).

Function
REQ-017 Organisation: 2-way set-associative, 64-bit blocks (2 words), per-set LRU bit, per-way valid and tag; offset = (addr-ADDR_BASE); word sel = offset[2], index = offset[2+log2(SETS):3], tag = offset[18:3+log2(SETS)] (10 bits at SETS=64).
REQ-018 States: IDLE, FILL0, FILL1, DONE, WRITE.
REQ-019 IDLE, no request: ready=1, sram_rd_en=sram_wr_en=0.
REQ-020 IDLE, rd_en hit: ready=1 and rdata=hit word combinationally in the same cycle (0-cycle latency); LRU[index] := other way at the edge.
REQ-021 IDLE, rd_en miss: ready=0; next state FILL0.
REQ-022 FILL0: sram_rd_en=1, sram_addr={addr[31:3],3'b000}; on edge with sram_ready=1 (not the first FILL0 cycle), latch sram_rdata as word0 and go to FILL1.
REQ-023 FILL1: sram_rd_en=1, sram_addr=block base+4; on completion edge (same rule as FILL0), write {word1,word0}, tag, valid=1 into victim way, LRU := other way, go to DONE.
REQ-024 Victim: way0 if invalid, else way1 if invalid, else way given by LRU bit.
REQ-025 DONE: ready=1, rdata=requested word from fill buffer, counted as a miss; next state IDLE unconditionally.
REQ-026 IDLE, wr_en: ready=0, go WRITE; WRITE drives sram_wr_en=1, sram_addr=addr, sram_wdata=wdata; on completion edge, if hit update that word in the hitting way (LRU unchanged), go DONE (ready=1 for one cycle).
REQ-027 Write policy: write-through, no-write-allocate; a write miss leaves the cache unchanged.
REQ-028 rd_en and wr_en together: treated as a write.
REQ-029 Requests shall not change while ready=0; behaviour otherwise undefined.

Reset
REQ-030 rst clears all valid and LRU bits, state := IDLE, sram_rd_en=sram_wr_en=0, hit_cnt=miss_cnt=0, regardless of any transaction in progress; the aborted fill writes nothing.

Configuration
REQ-031 CACHE_STATS_EN defined: hit_cnt increments on each read hit completion, miss_cnt on each DONE after a fill; both saturate at 16'hFFFF.
REQ-032 CACHE_STATS_EN undefined: counters not built; hit_cnt=miss_cnt=0 constantly; all other behaviour identical.

Structure
REQ-033 Package cache_pkg: state enum, TAG_W, IDX_W, ADDR_BASE default, block/word widths.
REQ-034 Sub-module cache_mem_2way: valid/tag/data/LRU arrays with combinational lookup (hit, hit_way, hit word) and synchronous writes; FSM and SRAM handshake stay in cache_controller.

Verification
REQ-035 After reset, rd_en addr=1024 -> miss: FILL0 at sram_addr 1024, FILL1 at 1028, DONE returns SRAM word; repeat read -> ready=1 same cycle, hit.
REQ-036 Fill 1024, then 1024+512 (same set 0) -> both ways valid; read 1024, then fill 1024+1024 -> evicts 1536 way (LRU); read 1024 still hits.
REQ-037 Write 32'hDEADBEEF to cached 1028 -> SRAM write issued, later read 1028 hits with 32'hDEADBEEF; write to uncached 2048 -> later read 2048 misses.
REQ-038 Assert rst during FILL1 -> state IDLE, enables 0, read of same address misses afterwards.
REQ-039 rd_en and wr_en together at 1024 -> write path (sram_wr_en=1, sram_rd_en=0).
REQ-040 With CACHE_STATS_EN, 3 misses and 5 hits -> miss_cnt=3, hit_cnt=5; without it both read 0.
